// File: rtl/snn_host_pkg.sv
// Shared types and default widths for the SNN host driver.
package snn_host_pkg;

    localparam int unsigned PKT_W_DEF = 30;
    localparam int unsigned OUT_W_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned TO_W_DEF  = 24;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoadEnd,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/snn_res_skid.sv
// One-entry valid/ready output register for the SNN result stream.
module snn_res_skid
    import snn_host_pkg::*;
#(
    parameter int unsigned W = OUT_W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Flush beats everything; a push on an accepted beat replaces it in place.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/snn_host_driver.sv
// Host-side sequencer: loads input packets into the SNN, runs it, drains results.
module snn_host_driver
    import snn_host_pkg::*;
#(
    parameter int unsigned PKT_W = PKT_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TO_W  = TO_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_num_pkts,
    input  logic             cfg_spike_en,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [PKT_W-1:0] src_data,
    output logic             packet_winc,
    output logic [PKT_W-1:0] packet_wdata,
    input  logic             packet_wfull,
    output logic             load_end,
    output logic             spike_en,
    input  logic             complete,
    output logic             packet_out_rinc,
    input  logic [OUT_W-1:0] packet_out,
    input  logic             packet_out_rempty,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] res_count
);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_num_pkts, r_sent, r_res_count;
    logic [TO_W-1:0]  r_timeout, r_wdog;
    logic             r_spike_en, r_timeout_err;

    logic w_start, w_abort, w_xfer, w_last, w_wdog_hit, w_rinc, w_flush;
    logic w_res_valid;

    // abort outranks start, and abort only means something outside IDLE
    assign w_start    = (r_state == StIdle) & start & ~abort;
    assign w_abort    = (r_state != StIdle) & abort;
    assign w_xfer     = (r_state == StLoad) & src_valid & ~packet_wfull;
    assign w_last     = w_xfer & (CNT_W'(r_sent + 1'b1) == r_num_pkts);
    assign w_wdog_hit = (r_state == StRun) & (r_timeout != '0) &
                        (TO_W'(r_wdog + 1'b1) == r_timeout);
    assign w_rinc     = (r_state == StRun) & ~packet_out_rempty & (~w_res_valid | res_ready);
    assign w_flush    = w_abort | w_wdog_hit;

    // Next-state decode; abort overrides any transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = (cfg_num_pkts == '0) ? StLoadEnd : StLoad;
                end
            end
            StLoad:    if (w_last) w_state_next = StLoadEnd;
            StLoadEnd: w_state_next = StRun;
            StRun: begin
                if (w_wdog_hit || (complete && packet_out_rempty && !w_res_valid)) begin
                    w_state_next = StDone;
                end
            end
            StDone:    w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
        if (w_abort) begin
            w_state_next = StIdle;
        end
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run configuration and counters; start samples config and clears everything
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_num_pkts    <= '0;
            r_spike_en    <= 1'b0;
            r_timeout     <= '0;
            r_sent        <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
            r_res_count   <= '0;
        end else if (w_start) begin
            r_num_pkts    <= cfg_num_pkts;
            r_spike_en    <= cfg_spike_en;
            r_timeout     <= cfg_timeout;
            r_sent        <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
            r_res_count   <= '0;
        end else begin
            if (w_xfer) r_sent <= r_sent + 1'b1;
            if (r_state == StRun) r_wdog <= r_wdog + 1'b1;
            if (w_wdog_hit) r_timeout_err <= 1'b1;
            if (w_res_valid && res_ready && (r_res_count != '1)) begin
                r_res_count <= r_res_count + 1'b1;
            end
        end
    end

    snn_res_skid #(
        .W (OUT_W)
    ) u_res_skid (
        .i_clk   (sys_clk),
        .i_rst_n (sys_reset_n),
        .i_flush (w_flush),
        .i_push  (w_rinc),
        .i_data  (packet_out),
        .o_valid (w_res_valid),
        .o_data  (res_data),
        .i_ready (res_ready)
    );

    assign src_ready       = (r_state == StLoad) & ~packet_wfull;
    assign packet_winc     = w_xfer;
    assign packet_wdata    = src_data;
    assign load_end        = (r_state == StLoadEnd) | (r_state == StRun) | (r_state == StDone);
    assign spike_en        = r_spike_en & ((r_state == StLoadEnd) | (r_state == StRun));
    assign packet_out_rinc = w_rinc;
    assign res_valid       = w_res_valid;
    assign busy            = (r_state != StIdle);
    assign done            = (r_state == StDone) & ~abort;
    assign timeout_err     = r_timeout_err;
    assign res_count       = r_res_count;

endmodule

// File: tb/tb_snn_host_driver.sv
// Scoreboard bench for snn_host_driver: packet and result streams checked against queues.
module tb_snn_host_driver;

    localparam int unsigned PKT_W = 30;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO_W  = 24;

    logic             sys_clk      = 1'b0;
    logic             sys_reset_n  = 1'b0;
    logic             start        = 1'b0;
    logic             abort        = 1'b0;
    logic [CNT_W-1:0] cfg_num_pkts = '0;
    logic             cfg_spike_en = 1'b0;
    logic [TO_W-1:0]  cfg_timeout  = '0;
    logic             src_valid    = 1'b0;
    logic             src_ready;
    logic [PKT_W-1:0] src_data;
    logic             packet_winc;
    logic [PKT_W-1:0] packet_wdata;
    logic             packet_wfull = 1'b0;
    logic             load_end;
    logic             spike_en;
    logic             complete     = 1'b0;
    logic             packet_out_rinc;
    logic [OUT_W-1:0] packet_out;
    logic             packet_out_rempty;
    logic             res_valid;
    logic             res_ready    = 1'b1;
    logic [OUT_W-1:0] res_data;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] res_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [PKT_W-1:0] exp_pkt_q[$];
    logic [OUT_W-1:0] exp_res_q[$];

    logic [31:0]      src_cnt = 32'd0;
    logic [OUT_W-1:0] fifo_mem [0:15];
    logic [7:0]       rd_ptr  = 8'd0;
    logic [7:0]       wr_ptr  = 8'd0;
    logic             res_tog = 1'b0;

    always #5 sys_clk = ~sys_clk;

    snn_host_driver #(
        .PKT_W (PKT_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W),
        .TO_W  (TO_W)
    ) u_dut (
        .sys_clk           (sys_clk),
        .sys_reset_n       (sys_reset_n),
        .start             (start),
        .abort             (abort),
        .cfg_num_pkts      (cfg_num_pkts),
        .cfg_spike_en      (cfg_spike_en),
        .cfg_timeout       (cfg_timeout),
        .src_valid         (src_valid),
        .src_ready         (src_ready),
        .src_data          (src_data),
        .packet_winc       (packet_winc),
        .packet_wdata      (packet_wdata),
        .packet_wfull      (packet_wfull),
        .load_end          (load_end),
        .spike_en          (spike_en),
        .complete          (complete),
        .packet_out_rinc   (packet_out_rinc),
        .packet_out        (packet_out),
        .packet_out_rempty (packet_out_rempty),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_data          (res_data),
        .busy              (busy),
        .done              (done),
        .timeout_err       (timeout_err),
        .res_count         (res_count)
    );

    // Source presents a fresh packet after every accepted transfer
    assign src_data = src_cnt[PKT_W-1:0] + PKT_W'(32'hA000);

    // Fall-through output FIFO model; pointer moves with non-blocking timing
    assign packet_out        = fifo_mem[rd_ptr[3:0]];
    assign packet_out_rempty = (rd_ptr == wr_ptr);
    always @(posedge sys_clk) if (packet_out_rinc) rd_ptr <= rd_ptr + 8'd1;

    // Result sink: ready toggles every cycle when res_tog is set
    always @(posedge sys_clk) res_ready <= res_tog ? ~res_ready : 1'b1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Stream monitors pop the scoreboards on every handshake
    always @(negedge sys_clk) begin
        #2;
        if (sys_reset_n && packet_winc) begin
            if (exp_pkt_q.size() == 0) check_val("winc_extra", 32'(packet_winc), 32'd0);
            else check_val("wdata", 32'(packet_wdata), 32'(exp_pkt_q.pop_front()));
            src_cnt = src_cnt + 32'd1;
        end
        if (sys_reset_n && res_valid && res_ready) begin
            if (exp_res_q.size() == 0) check_val("res_extra", 32'(res_valid), 32'd0);
            else check_val("res_data", 32'(res_data), 32'(exp_res_q.pop_front()));
        end
    end

    task automatic start_run(input logic [CNT_W-1:0] num, input logic spk,
                             input logic [TO_W-1:0] to);
        @(negedge sys_clk);
        cfg_num_pkts = num;
        cfg_spike_en = spk;
        cfg_timeout  = to;
        start        = 1'b1;
        @(negedge sys_clk);
        start        = 1'b0;
        cfg_num_pkts = '0;
        cfg_spike_en = 1'b0;
        cfg_timeout  = '0;
    endtask

    task automatic run_until_done(input int budget, output int first_at, output int n_done);
        first_at = -1;
        n_done   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            #1;
            if (done) begin
                n_done++;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        int nw, first_w, last_w, le_rise, at, nd, le_seen, done_seen;
        for (int k = 0; k < 16; k++) fifo_mem[k] = '0;

        // Reset, with start and src_valid held high to show they are ignored
        start = 1'b1;
        cfg_num_pkts = 16'd2;
        src_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_load_end", 32'(load_end), 0);
        check_val("rst_spike_en", 32'(spike_en), 0);
        check_val("rst_done", 32'(done), 0);
        check_val("rst_res_valid", 32'(res_valid), 0);
        check_val("rst_res_data", 32'(res_data), 0);
        check_val("rst_res_count", 32'(res_count), 0);
        check_val("rst_timeout_err", 32'(timeout_err), 0);
        check_val("rst_src_ready", 32'(src_ready), 0);
        check_val("rst_winc", 32'(packet_winc), 0);
        check_val("rst_rinc", 32'(packet_out_rinc), 0);
        start = 1'b0;
        cfg_num_pkts = '0;
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        #1;
        check_val("post_rst_idle", 32'(busy), 0);

        // Four packets back to back, load_end one cycle after the last write
        for (int k = 0; k < 4; k++) exp_pkt_q.push_back(PKT_W'(src_cnt + 32'hA000 + k));
        src_valid = 1'b1;
        start_run(16'd4, 1'b0, '0);
        nw = 0; first_w = -1; last_w = -1; le_rise = -1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge sys_clk);
            #1;
            if (packet_winc) begin
                nw++;
                if (first_w < 0) first_w = i;
                last_w = i;
            end
            if (load_end && le_rise < 0) le_rise = i;
        end
        check_val("a_winc_count", nw, 4);
        check_val("a_first_winc", first_w, 0);
        check_val("a_winc_span", last_w - first_w, 3);
        check_val("a_load_end_rise", le_rise, last_w + 1);
        check_val("a_spike_off", 32'(spike_en), 0);
        check_val("a_src_ready_run", 32'(src_ready), 0);
        complete = 1'b1;
        run_until_done(10, at, nd);
        complete = 1'b0;
        check_val("a_done_pulses", nd, 1);
        check_val("a_idle", 32'(busy), 0);
        check_val("a_pkt_q_empty", exp_pkt_q.size(), 0);

        // Eight packets with a three-cycle full stall after the second
        for (int k = 0; k < 8; k++) exp_pkt_q.push_back(PKT_W'(src_cnt + 32'hA000 + k));
        start_run(16'd8, 1'b0, '0);
        nw = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge sys_clk);
            packet_wfull = (i >= 2 && i < 5);
            #1;
            if (packet_wfull) begin
                check_val("b_stall_ready", 32'(src_ready), 0);
                check_val("b_stall_winc", 32'(packet_winc), 0);
            end
            if (packet_winc) nw++;
        end
        packet_wfull = 1'b0;
        check_val("b_winc_count", nw, 8);
        check_val("b_pkt_q_empty", exp_pkt_q.size(), 0);
        check_val("b_load_end", 32'(load_end), 1);
        complete = 1'b1;
        run_until_done(10, at, nd);
        complete = 1'b0;
        check_val("b_done_pulses", nd, 1);
        src_valid = 1'b0;

        // Zero packets, spike enabled, five results drained with toggling ready
        for (int k = 0; k < 5; k++) begin
            fifo_mem[wr_ptr[3:0]] = OUT_W'(8'h11 + k);
            wr_ptr = wr_ptr + 8'd1;
            exp_res_q.push_back(OUT_W'(8'h11 + k));
        end
        @(negedge sys_clk);
        #1;
        check_val("c_idle_no_rinc", 32'(packet_out_rinc), 0);
        res_tog = 1'b1;
        start_run('0, 1'b1, '0);
        #1;
        check_val("c_load_end_rise", 32'(load_end), 1);
        check_val("c_spike_rise", 32'(spike_en), 1);
        check_val("c_load_end_no_rinc", 32'(packet_out_rinc), 0);
        @(negedge sys_clk);
        #1;
        check_val("c_spike_run", 32'(spike_en), 1);
        complete = 1'b1;
        run_until_done(40, at, nd);
        complete = 1'b0;
        res_tog = 1'b0;
        check_val("c_done_pulses", nd, 1);
        check_val("c_res_count", 32'(res_count), 5);
        check_val("c_res_q_empty", exp_res_q.size(), 0);
        check_val("c_fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
        check_val("c_spike_idle", 32'(spike_en), 0);
        check_val("c_load_end_idle", 32'(load_end), 0);

        // Watchdog of 100 cycles with complete never asserted
        start_run('0, 1'b0, TO_W'(100));
        #1;
        check_val("d_load_end", 32'(load_end), 1);
        run_until_done(120, at, nd);
        check_val("d_done_at", at, 100);
        check_val("d_done_pulses", nd, 1);
        check_val("d_timeout_err", 32'(timeout_err), 1);
        check_val("d_res_count", 32'(res_count), 0);

        // Abort in LOAD after two of eight packets
        for (int k = 0; k < 2; k++) exp_pkt_q.push_back(PKT_W'(src_cnt + 32'hA000 + k));
        src_valid = 1'b1;
        start_run(16'd8, 1'b0, '0);
        nw = 0; le_seen = 0; done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (i == 2) begin
                abort = 1'b1;
                src_valid = 1'b0;
            end
            if (i == 3) abort = 1'b0;
            #1;
            if (i == 0) check_val("e_err_cleared", 32'(timeout_err), 0);
            if (i == 3) check_val("e_idle_after_abort", 32'(busy), 0);
            if (packet_winc) nw++;
            if (load_end) le_seen++;
            if (done) done_seen++;
        end
        check_val("e_winc_count", nw, 2);
        check_val("e_no_load_end", le_seen, 0);
        check_val("e_no_done", done_seen, 0);
        check_val("e_pkt_q_empty", exp_pkt_q.size(), 0);

        // Simultaneous start and abort in IDLE: abort wins
        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        cfg_num_pkts = 16'd3;
        @(negedge sys_clk);
        start = 1'b0;
        abort = 1'b0;
        cfg_num_pkts = '0;
        #1;
        check_val("f_abort_wins", 32'(busy), 0);

        repeat (2) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/snn_host_driver.md
SNN_HOST_DRIVER -- requirements
Module: snn_host_driver

Interface
REQ-001 SHALL have parameters: PKT_W, default 30, SNN input packet width; OUT_W, default 8, SNN output packet width; CNT_W, default 16, packet/result counter width; TO_W, default 24, watchdog counter width.
REQ-002 SHALL have ports, clock and reset first; the block runs on one clock, and reset is synchronous and active-low:
- sys_clk  in  1  CPU-side clock
- sys_reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin a run; ignored unless in IDLE
- abort  in  1  one-cycle request to cancel a run; returns to IDLE
- cfg_num_pkts  in  CNT_W  number of input packets to send, sampled at start
- cfg_spike_en  in  1  drive spike_en during the run, sampled at start
- cfg_timeout  in  TO_W  maximum RUN cycles, sampled at start; 0 disables the watchdog
- src_valid / src_ready  in / out  1 / 1  input packet stream handshake
- src_data  in  PKT_W  input packet
- packet_winc  out  1  SNN packet FIFO write strobe
- packet_wdata  out  PKT_W  SNN packet FIFO data
- packet_wfull  in  1  SNN packet FIFO full
- load_end  out  1  level: loading finished
- spike_en  out  1  level: spike output enable
- complete  in  1  SNN run complete, already synchronised to sys_clk
- packet_out_rinc  out  1  SNN output FIFO pop
- packet_out  in  OUT_W  SNN output FIFO head (fall-through)
- packet_out_rempty  in  1  SNN output FIFO empty
- res_valid / res_ready  out / in  1 / 1  result stream handshake
- res_data  out  OUT_W  result packet
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse on run end
- timeout_err  out  1  sticky; cleared at the next start
- res_count  out  CNT_W  results delivered in the current or last run

Function
REQ-003 SHALL implement an FSM with states IDLE, LOAD, LOAD_END, RUN and DONE.
REQ-004 IDLE -> LOAD on start; if cfg_num_pkts==0, IDLE -> LOAD_END directly.
REQ-005 In LOAD: src_ready = ~packet_wfull; packet_winc = src_valid & ~packet_wfull; packet_wdata = src_data (combinational pass-through); on each transfer the sent counter increments.
REQ-006 LOAD -> LOAD_END in the cycle after the transfer that makes sent equal cfg_num_pkts.
REQ-007 src_ready SHALL be 0 in every state except LOAD, and no packet_winc SHALL be issued beyond cfg_num_pkts.
REQ-008 LOAD_END lasts one cycle and asserts load_end; load_end then stays 1 through RUN and DONE and is 0 in IDLE and LOAD.
REQ-009 spike_en = sampled cfg_spike_en while in LOAD_END or RUN, otherwise 0.
REQ-010 RUN drains the SNN output FIFO through a one-entry output register:
- packet_out_rinc = ~packet_out_rempty & (~res_valid | res_ready)
- the popped packet_out is loaded into res_data, with res_valid=1, on the next edge
REQ-011 res_count SHALL increment on each res_valid & res_ready, and saturate at all-ones.
REQ-012 RUN -> DONE when complete==1, packet_out_rempty==1 and res_valid==0 in the same cycle.
REQ-013 RUN watchdog: the cycle counter runs in RUN; when it reaches a nonzero cfg_timeout, set timeout_err and go to DONE. Any pending res_valid beat is discarded.
REQ-014 DONE lasts one cycle, pulses done, then goes to IDLE.
REQ-015 abort in any non-IDLE state SHALL:
- go to IDLE on the next edge
- clear res_valid, load_end and spike_en
- not pulse done
REQ-016 If abort and start arrive in the same cycle, abort wins.
REQ-017 start SHALL clear res_count, the sent counter, the watchdog counter and timeout_err.
REQ-018 packet_out_rinc SHALL be 0 outside RUN; SNN output arriving before RUN stays in the FIFO.

Reset
REQ-019 On sys_reset_n==0 at a sys_clk edge, the block SHALL reset to:
- state IDLE
- all counters 0
- res_valid, packet_winc, packet_out_rinc, load_end, spike_en, done, busy and timeout_err 0
- res_data 0
REQ-020 A reset mid-run SHALL abandon the run without a done pulse.

Structure
REQ-021 The state encoding and the default widths SHALL live in the shared package snn_host_pkg.
REQ-022 The output register SHALL be the single sub-module snn_res_skid (one-entry valid/ready register).

Verification
REQ-023 cfg_num_pkts=4, src always valid, wfull=0: exactly 4 packet_winc on 4 consecutive cycles, and load_end rises 1 cycle after the 4th write.
REQ-024 packet_wfull held high for 3 cycles mid-load: no writes and src_ready=0 during those cycles, then the 6 remaining packets are sent in order.
REQ-025 5 output packets 0x11..0x15 with res_ready toggling every cycle: res_data shows 0x11..0x15 in order, res_count=5, and done pulses after complete=1.
REQ-026 cfg_timeout=100 and complete never asserted: timeout_err=1 and done pulses 100 cycles after RUN entry.
REQ-027 abort in LOAD after 2 of 8 packets: IDLE next cycle, load_end never asserted, no done pulse.
REQ-028 cfg_num_pkts=0 with cfg_spike_en=1: load_end and spike_en rise 1 cycle after start.
